// File: rtl/aclk_key_entry.sv
// aclk_key_entry: keypad time-entry controller for the alarm clock.
// Shifts BCD digits into a 4-digit buffer and range-checks the entry on a
// button press. It then strobes a load into the time counter or the alarm
// register, or flags an entry error. An idle entry is abandoned after
// TIMEOUT_SEC seconds.
//
// Handshake: key_valid, time_button, alarm_button and one_second are
// single-cycle strobes with no back-pressure. Every output is a register,
// so each strobe (load_new_c, load_new_a, entry_error) follows one cycle
// after the sampled input and lasts exactly one cycle.
module aclk_key_entry #(
   parameter int unsigned TIMEOUT_SEC = 10,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       one_second,
   input  logic       key_valid,
   input  logic [3:0] key,
   input  logic       time_button,
   input  logic       alarm_button,
   output logic [3:0] new_time_ms_hr,
   output logic [3:0] new_time_ls_hr,
   output logic [3:0] new_time_ms_min,
   output logic [3:0] new_time_ls_min,
   output logic       load_new_c,
   output logic       load_new_a,
   output logic       show_new_time,
   output logic       entry_error,
   output logic       dbg_state
);

   typedef enum logic {
      IDLE  = 1'b0,
      ENTRY = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_SEC - 1);

   state_t           state_q;
   logic [3:0]       ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
   logic [2:0]       cnt_q;
   logic [CNT_W-1:0] tmo_q;
   logic             load_c_q, load_a_q, err_q;

   logic key_digit;
   logic any_btn;
   logic both_btn;
   logic entry_ok;

   // Decode the incoming strobes and range-check the current buffer as HH:MM
   always_comb begin
      key_digit = key_valid && (key <= 4'd9);
      any_btn   = time_button || alarm_button;
      both_btn  = time_button && alarm_button;
      entry_ok  = (cnt_q == 3'd4) &&
                  (ms_hr_q <= 4'd2) &&
                  (ms_min_q <= 4'd5) &&
                  (ls_min_q <= 4'd9) &&
                  ((ms_hr_q == 4'd2) ? (ls_hr_q <= 4'd3) : (ls_hr_q <= 4'd9));
   end

   // Entry FSM: buffer, digit count, inactivity timer and registered strobes.
   // A button outranks a key or a timeout expiry in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         ms_hr_q  <= 4'd0;
         ls_hr_q  <= 4'd0;
         ms_min_q <= 4'd0;
         ls_min_q <= 4'd0;
         cnt_q    <= 3'd0;
         tmo_q    <= '0;
         load_c_q <= 1'b0;
         load_a_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         load_c_q <= 1'b0;
         load_a_q <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               // A button is meaningless here, and it still swallows a
               // simultaneous key.
               if (key_digit && !any_btn) begin
                  ms_hr_q  <= 4'd0;
                  ls_hr_q  <= 4'd0;
                  ms_min_q <= 4'd0;
                  ls_min_q <= key;
                  cnt_q    <= 3'd1;
                  tmo_q    <= '0;
                  state_q  <= ENTRY;
               end
            end
            ENTRY: begin
               if (any_btn) begin
                  state_q <= IDLE;
                  cnt_q   <= 3'd0;
                  tmo_q   <= '0;
                  if (!both_btn && entry_ok) begin
                     // Buffer is left intact so the target can load it.
                     load_c_q <= time_button;
                     load_a_q <= alarm_button;
                  end else begin
                     err_q    <= 1'b1;
                     ms_hr_q  <= 4'd0;
                     ls_hr_q  <= 4'd0;
                     ms_min_q <= 4'd0;
                     ls_min_q <= 4'd0;
                  end
               end else if (key_digit) begin
                  ms_hr_q  <= ls_hr_q;
                  ls_hr_q  <= ms_min_q;
                  ms_min_q <= ls_min_q;
                  ls_min_q <= key;
                  if (cnt_q != 3'd4) begin
                     cnt_q <= cnt_q + 3'd1;
                  end
                  tmo_q <= '0;
               end else if (one_second) begin
                  if (tmo_q == TMO_LAST) begin
                     state_q  <= IDLE;
                     cnt_q    <= 3'd0;
                     tmo_q    <= '0;
                     ms_hr_q  <= 4'd0;
                     ls_hr_q  <= 4'd0;
                     ms_min_q <= 4'd0;
                     ls_min_q <= 4'd0;
                  end else begin
                     tmo_q <= tmo_q + CNT_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign new_time_ms_hr  = ms_hr_q;
   assign new_time_ls_hr  = ls_hr_q;
   assign new_time_ms_min = ms_min_q;
   assign new_time_ls_min = ls_min_q;
   assign load_new_c      = load_c_q;
   assign load_new_a      = load_a_q;
   assign entry_error     = err_q;
   assign show_new_time   = (state_q == ENTRY);
   assign dbg_state       = state_q;

endmodule

// File: doc/aclk_key_entry.md
Name: aclk_key_entry

Overview:
- Front-end time-entry controller for the alarm clock.
- Collects BCD digits from the debounced keypad decoder into a 4-digit entry buffer, range-checks the entry, and drives the load interface of the time counter and the alarm register.
- Sits between the keypad decoder and the counter/alarm blocks. Its outputs wire directly to their new-time digit inputs and load strobes.

Parameters:
- TIMEOUT_SEC, 10: whole seconds of keypad inactivity in ENTRY before the entry is abandoned (1..255).
- CNT_W, 8: width of the inactivity counter; must hold TIMEOUT_SEC.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- one_second  input  1  one-cycle pulse once per second, from the timegen
- key_valid  input  1  one-cycle strobe, key field valid
- key  input  4  key code; 0-9 = digit, 10-15 = non-digit (ignored)
- time_button  input  1  one-cycle strobe, commit entry as current time
- alarm_button  input  1  one-cycle strobe, commit entry as alarm time
- new_time_ms_hr  output  4  entry buffer, tens of hours
- new_time_ls_hr  output  4  entry buffer, units of hours
- new_time_ms_min  output  4  entry buffer, tens of minutes
- new_time_ls_min  output  4  entry buffer, units of minutes
- load_new_c  output  1  one-cycle strobe to the counter: load new_time_*
- load_new_a  output  1  one-cycle strobe to the alarm register: load new_time_*
- show_new_time  output  1  display mux select, high while an entry is in progress
- entry_error  output  1  one-cycle strobe, commit rejected

Behaviour:
- **Reset (reset=0, async):**
  - state=IDLE.
  - All four digit outputs = 0, digit_cnt = 0, timeout counter = 0.
  - load_new_c, load_new_a, show_new_time, entry_error = 0.
  - Reset mid-entry discards the buffer immediately; no load strobe is produced.
- **All outputs are registered.** A strobe appears on the clock edge after the sampled input, i.e. 1-cycle latency.
- **States:** IDLE, ENTRY. show_new_time = (state==ENTRY).
- **IDLE:**
  - key_valid with key<=9: buffer = {0,0,0,key}, digit_cnt=1, timeout=0, go to ENTRY.
  - key>9: ignored.
  - time_button or alarm_button: ignored, no strobes.
- **ENTRY, digit key:**
  - Shift left: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key.
  - digit_cnt saturates at 4; a 5th and later digit drops the oldest digit.
  - timeout resets to 0.
- **ENTRY, timeout:**
  - Each one_second pulse with no key in the same cycle increments timeout.
  - When timeout reaches TIMEOUT_SEC-1 and one_second arrives: go to IDLE, clear buffer and digit_cnt, no strobes.
- **ENTRY, commit on time_button xor alarm_button:**
  - The entry is valid iff all of the following hold:
    - digit_cnt==4
    - ms_hr<=2
    - ls_min<=9
    - ms_min<=5
    - ls_hr<=9 when ms_hr<2; ls_hr<=3 when ms_hr==2
  - Valid: pulse load_new_c (time_button) or load_new_a (alarm_button) for one cycle. The buffer holds its value during and after the strobe. Go to IDLE; the buffer is cleared on the next key entry, not on commit.
  - Invalid: pulse entry_error, clear buffer, go to IDLE.
- **Simultaneous events:**
  - Button and key_valid in the same cycle: the button wins and the key is discarded.
  - time_button and alarm_button in the same cycle while in ENTRY: entry_error, no load, go to IDLE.
  - Button and timeout expiry in the same cycle: the button wins.
- load_new_c and load_new_a are never high in the same cycle. Each is never high for more than one cycle per commit.

Test Plan:
- Keys 1,2,3,4 then time_button -> digits 1/2/3/4; load_new_c=1 for exactly one cycle, one cycle after the button; show_new_time falls with it; load_new_a stays 0.
- Keys 2,3,5,9 then alarm_button -> load_new_a pulse with 23:59. Keys 2,4,0,0 then time_button -> entry_error, no load, digits cleared to 0.
- Keys 9,1,2,3,4 (five digits) then time_button -> buffer 1,2,3,4 (oldest dropped), load_new_c pulse. Keys 1,2 then time_button -> entry_error (digit_cnt=2).
- TIMEOUT_SEC=3: key 5, then three one_second pulses with no keys -> state IDLE, show_new_time=0, buffer 0, no strobes. Repeat with a key after the 2nd pulse -> stays in ENTRY.
- Corner events:
  - key_valid and time_button together after 4 digits 0,9,5,9 -> load_new_c with 09:59, key not shifted in.
  - Both buttons together -> entry_error only.
  - key 12 in IDLE -> no state change.
- Pull reset low after 3 digits, mid-entry -> all outputs 0 immediately (asynchronous). After release, time_button -> no strobe.
